// File: rtl/dma_periph_pkg.sv
// Shared definitions for the DMA peripheral receive channel.
// Contents:
//   DEFAULT_DEPTH  default FIFO depth
//   state_e        channel state machine encoding (IDLE, REQ, XFER, HOLD)
//   ptr_width()    FIFO pointer width for a given depth
//   cnt_width()    FIFO occupancy width for a given depth (holds 0..depth)
package dma_periph_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        HOLD = 2'd3
    } state_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO with a combinationally read head entry.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and data (ignored while full)
//   pop          read request (ignored while empty)
//   head         entry at the read pointer
//   full, empty  occupancy flags
//   count        occupancy, 0..DEPTH
module dma_sync_fifo
    import dma_periph_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/dma_periph_fifo.sv
// Peripheral receive channel feeding one 8237A DMA channel (I/O-to-memory).
// Buffers source bytes, raises DREQ at DREQ_THRESHOLD occupancy, drives DB while
// DACK and IOR_N are active, and pops one byte on each IOR_N trailing edge.
// Ports:
//   CLK, RESET             clock, asynchronous active-low reset
//   src_data/valid/ready   local source push interface
//   src_last               last byte of a block (DMA_PERIPH_EOP_EN only)
//   DREQ                   registered DMA request
//   DACK, IOR_N, EOP_N     DMA acknowledge, read strobe, end-of-process
//   DB, DB_OE              FIFO head byte and bus drive enable
//   EOP_OUT_N              peripheral-initiated EOP (DMA_PERIPH_EOP_EN only)
//   done                   one-cycle pulse on normal transfer termination
//   count                  FIFO occupancy
// Build option: define DMA_PERIPH_EOP_EN to carry src_last through the FIFO and
// terminate the transfer on the pop of a last-flagged byte.
module dma_periph_fifo
    import dma_periph_pkg::*;
#(
    parameter int unsigned DEPTH          = DEFAULT_DEPTH,
    parameter int unsigned DREQ_THRESHOLD = 1
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [7:0]                  src_data,
    input  logic                        src_valid,
    output logic                        src_ready,
`ifdef DMA_PERIPH_EOP_EN
    input  logic                        src_last,
`endif
    output logic                        DREQ,
    input  logic                        DACK,
    input  logic                        IOR_N,
    input  logic                        EOP_N,
    output logic [7:0]                  DB,
    output logic                        DB_OE,
`ifdef DMA_PERIPH_EOP_EN
    output logic                        EOP_OUT_N,
`endif
    output logic                        done,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned CW = cnt_width(DEPTH);
`ifdef DMA_PERIPH_EOP_EN
    localparam int unsigned FW = 9;
`else
    localparam int unsigned FW = 8;
`endif

    state_e        state_q, state_d;
    logic          dreq_q, dreq_d;
    logic          done_q, done_d;
    logic          ior_q;
    logic [7:0]    last_q;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          head_last;
    logic [FW-1:0] wdata;
    logic [FW-1:0] head;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;

`ifdef DMA_PERIPH_EOP_EN
    assign wdata     = {src_last, src_data};
    assign head_last = head[8] && !empty;
    assign EOP_OUT_N = !(DB_OE && head_last);
`else
    assign wdata     = src_data;
    assign head_last = 1'b0;
`endif

    assign src_ready  = !full;
    assign push       = src_valid && src_ready;
    // Trailing (rising) edge of the read strobe while acknowledged.
    assign pop        = !ior_q && IOR_N && DACK && !empty;
    assign count_next = fifo_count + CW'(push) - CW'(pop);

    dma_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_count >= CW'(DREQ_THRESHOLD)) state_d = REQ;
            end
            REQ: begin
                if (DACK) state_d = XFER;
            end
            XFER: begin
                if (!EOP_N || (pop && (count_next == '0)) || (pop && head_last)) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end else if (!DACK) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered from the next state so DREQ drops on the edge entering HOLD.
        dreq_d = (state_d == REQ) || ((state_d == XFER) && (count_next != '0));
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            dreq_q  <= 1'b0;
            done_q  <= 1'b0;
            ior_q   <= 1'b1;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            dreq_q  <= dreq_d;
            done_q  <= done_d;
            ior_q   <= IOR_N;
            if (pop) last_q <= head[7:0];
        end
    end

    // With the FIFO empty the bus keeps showing the most recently popped byte.
    assign DB    = empty ? last_q : head[7:0];
    assign DB_OE = DACK && !IOR_N;
    assign DREQ  = dreq_q;
    assign done  = done_q;
    assign count = fifo_count;

endmodule

// File: tb/tb_dma_periph_fifo.sv
module tb_dma_periph_fifo;

    logic       CLK;
    logic       RESET;
    logic [7:0] src_data;
    logic       src_valid;
    logic       DACK;
    logic       IOR_N;
    logic       EOP_N;
`ifdef DMA_PERIPH_EOP_EN
    logic       src_last;
    logic       eop_out_n;
    logic       eop_out_n4;
`endif

    logic       src_ready, src_ready4;
    logic       dreq, dreq4;
    logic [7:0] db, db4;
    logic       db_oe, db_oe4;
    logic       done, done4;
    logic [4:0] cnt, cnt4;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb[$];

    dma_periph_fifo #(
        .DEPTH          (16),
        .DREQ_THRESHOLD (1)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
`ifdef DMA_PERIPH_EOP_EN
        .src_last  (src_last),
`endif
        .DREQ      (dreq),
        .DACK      (DACK),
        .IOR_N     (IOR_N),
        .EOP_N     (EOP_N),
        .DB        (db),
        .DB_OE     (db_oe),
`ifdef DMA_PERIPH_EOP_EN
        .EOP_OUT_N (eop_out_n),
`endif
        .done      (done),
        .count     (cnt)
    );

    dma_periph_fifo #(
        .DEPTH          (16),
        .DREQ_THRESHOLD (4)
    ) dut4 (
        .CLK       (CLK),
        .RESET     (RESET),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready4),
`ifdef DMA_PERIPH_EOP_EN
        .src_last  (src_last),
`endif
        .DREQ      (dreq4),
        .DACK      (DACK),
        .IOR_N     (IOR_N),
        .EOP_N     (EOP_N),
        .DB        (db4),
        .DB_OE     (db_oe4),
`ifdef DMA_PERIPH_EOP_EN
        .EOP_OUT_N (eop_out_n4),
`endif
        .done      (done4),
        .count     (cnt4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       dack;
        logic       ior_n;
        logic       exp_dreq;
        logic       exp_oe;
        logic [7:0] exp_db;
        logic [4:0] exp_cnt;
        logic       exp_done;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET     = 1'b0;
        src_valid = 1'b0;
        src_data  = 8'h00;
        DACK      = 1'b0;
        IOR_N     = 1'b1;
        EOP_N     = 1'b1;
`ifdef DMA_PERIPH_EOP_EN
        src_last  = 1'b0;
`endif
        sb.delete();
        step();
        step();
        RESET = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        src_valid = 1'b1;
        src_data  = d;
        if (sb.size() < 16) sb.push_back(d);
        step();
        src_valid = 1'b0;
    endtask

    // Two-cycle IOR_N low pulse; head byte checked against the scoreboard while driven.
    task automatic strobe(input bit with_push, input logic [7:0] pdata);
        logic [7:0] exp;
        IOR_N = 1'b0;
        step();
        step();
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL strobe_sb: got empty scoreboard, expected a byte at %0t", $time);
        end else begin
            exp = sb.pop_front();
            chk("strobe_db", 32'(db), 32'(exp));
            chk("strobe_db4", 32'(db4), 32'(exp));
            chk("strobe_oe", 32'(db_oe), 32'd1);
        end
        IOR_N = 1'b1;
        if (with_push) begin
            src_valid = 1'b1;
            src_data  = pdata;
            sb.push_back(pdata);
        end
        step();
        src_valid = 1'b0;
        chk("strobe_count", 32'(cnt), 32'(sb.size()));
    endtask

    task automatic wait_dreq(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles; i++) begin
            if (dreq) break;
            step();
        end
        chk(name, 32'(dreq), 32'd1);
    endtask

    initial begin
        //                valid data   dack ior  dreq oe   db     cnt  done
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0};

        // Reset values, sampled while reset is held.
        RESET     = 1'b0;
        src_valid = 1'b0;
        src_data  = 8'h00;
        DACK      = 1'b0;
        IOR_N     = 1'b1;
        EOP_N     = 1'b1;
`ifdef DMA_PERIPH_EOP_EN
        src_last  = 1'b0;
`endif
        #1;
        chk("rst_dreq", 32'(dreq), 32'd0);
        chk("rst_oe", 32'(db_oe), 32'd0);
        chk("rst_db", 32'(db), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd1);
`ifdef DMA_PERIPH_EOP_EN
        chk("rst_eop_out", 32'(eop_out_n), 32'd1);
`endif
        do_reset();

        // Single-byte transfer, then a strobe against an empty FIFO.
        for (int i = 0; i < 11; i++) begin
            src_valid = tbl[i].valid;
            src_data  = tbl[i].data;
            DACK      = tbl[i].dack;
            IOR_N     = tbl[i].ior_n;
            step();
            chk($sformatf("t1_dreq[%0d]", i), 32'(dreq), 32'(tbl[i].exp_dreq));
            chk($sformatf("t1_oe[%0d]", i), 32'(db_oe), 32'(tbl[i].exp_oe));
            chk($sformatf("t1_db[%0d]", i), 32'(db), 32'(tbl[i].exp_db));
            chk($sformatf("t1_cnt[%0d]", i), 32'(cnt), 32'(tbl[i].exp_cnt));
            chk($sformatf("t1_done[%0d]", i), 32'(done), 32'(tbl[i].exp_done));
        end
        src_valid = 1'b0;

        // Threshold of 4 on dut4.
        do_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        step();
        step();
        chk("t2_dreq4_at3", 32'(dreq4), 32'd0);
        push_byte(8'h44);
        chk("t2_dreq4_push_edge", 32'(dreq4), 32'd0);
        step();
        chk("t2_dreq4_next", 32'(dreq4), 32'd1);
        DACK = 1'b1;
        step();
        for (int i = 0; i < 4; i++) strobe(1'b0, 8'h00);
        chk("t2_done4", 32'(done4), 32'd1);
        chk("t2_dreq4_end", 32'(dreq4), 32'd0);
        DACK = 1'b0;
        step();

        // Fill to full, overflow drop, simultaneous push and pop, full drain.
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'(i * 7 + 3));
        chk("t3_full_count", 32'(cnt), 32'd16);
        chk("t3_full_ready", 32'(src_ready), 32'd0);
        push_byte(8'hEE);
        chk("t3_overflow_count", 32'(cnt), 32'd16);
        DACK = 1'b1;
        step();
        strobe(1'b0, 8'h00);
        strobe(1'b1, 8'h77);
        chk("t3_pushpop_count", 32'(cnt), 32'd15);
        push_byte(8'h88);
        chk("t3_refill_count", 32'(cnt), 32'd16);
        for (int i = 0; i < 16; i++) strobe(1'b0, 8'h00);
        DACK = 1'b0;
        step();
        step();

        // EOP_N from the controller with bytes remaining.
        do_reset();
        for (int i = 0; i < 8; i++) push_byte(8'(8'h40 + i));
        DACK = 1'b1;
        step();
        for (int i = 0; i < 3; i++) strobe(1'b0, 8'h00);
        EOP_N = 1'b0;
        step();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_dreq_hold", 32'(dreq), 32'd0);
        chk("t4_count", 32'(cnt), 32'd5);
        EOP_N = 1'b1;
        DACK  = 1'b0;
        step();
        chk("t4_done_pulse", 32'(done), 32'd0);
        chk("t4_dreq_idle", 32'(dreq), 32'd0);
        wait_dreq(6, "t4_dreq_again");
        chk("t4_count_again", 32'(cnt), 32'd5);
        DACK = 1'b1;
        step();
        for (int i = 0; i < 5; i++) strobe(1'b0, 8'h00);
        DACK = 1'b0;
        step();

        // DACK withdrawn mid-transfer, then an asynchronous reset mid-strobe.
        do_reset();
        push_byte(8'hC1);
        push_byte(8'hC2);
        DACK = 1'b1;
        step();
        chk("t5_dreq_xfer", 32'(dreq), 32'd1);
        DACK = 1'b0;
        step();
        chk("t5_abort_done", 32'(done), 32'd0);
        chk("t5_abort_dreq", 32'(dreq), 32'd0);
        chk("t5_abort_count", 32'(cnt), 32'd2);
        step();
        chk("t5_idle_dreq", 32'(dreq), 32'd0);
        wait_dreq(6, "t5_dreq_again");
        DACK = 1'b1;
        step();
        IOR_N = 1'b0;
        step();
        #2;
        RESET = 1'b0;
        #1;
        chk("t5_rst_count", 32'(cnt), 32'd0);
        chk("t5_rst_dreq", 32'(dreq), 32'd0);
        chk("t5_rst_ready", 32'(src_ready), 32'd1);
        DACK  = 1'b0;
        IOR_N = 1'b1;
        sb.delete();
        step();
        RESET = 1'b1;
        step();

`ifdef DMA_PERIPH_EOP_EN
        // Last-flagged byte terminates the transfer even with data remaining.
        do_reset();
        push_byte(8'h31);
        push_byte(8'h32);
        src_last = 1'b1;
        push_byte(8'h33);
        src_last = 1'b0;
        push_byte(8'h34);
        DACK = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            IOR_N = 1'b0;
            step();
            chk($sformatf("t6_eop_out_low[%0d]", k), 32'(eop_out_n), (k == 2) ? 32'd0 : 32'd1);
            chk($sformatf("t6_db[%0d]", k), 32'(db), 32'(sb.pop_front()));
            step();
            IOR_N = 1'b1;
            step();
            chk($sformatf("t6_eop_out_high[%0d]", k), 32'(eop_out_n), 32'd1);
        end
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_count", 32'(cnt), 32'd1);
        chk("t6_dreq", 32'(dreq), 32'd0);
        DACK = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
